shift_arbiter: RTL and testbench
================================

# shift_arbiter

Two-requester arbiter and two-stage pipeline controller for the shared 16-bit logical left shifter. It takes shift requests from the execute path (port 0) and the load/store alignment path (port 1), and grants one request per cycle using round-robin priority. The granted operands are registered and sent to the shifter, and the result is returned with the owner's valid flag under backpressure. The shifter itself is combinational and is connected at the level above through the sh_* ports.

## Interface
- No parameters; data width is fixed at 16 and count width at 4.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  request present on that port.
- req0_in, req1_in  in  16  operand to shift.
- req0_cnt, req1_cnt  in  4  left-shift amount, 0–15.
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready.
- resp0_valid, resp1_valid  out  1  result in resp_data belongs to that port.
- resp0_ready, resp1_ready  in  1  owner consumes the result this cycle.
- resp_data  out  16  registered shift result.
- sh_in  out  16  operand to the shifter, driven from stage-1 registers.
- sh_cnt  out  4  count to the shifter, driven from stage-1 registers.
- sh_out  in  16  combinational shifter result.
- busy  out  1  s1_valid | s2_valid.

## Operation
- **Stage 1 (S1) registers:** s1_valid, s1_owner, s1_in, s1_cnt.
- **Stage 2 (S2) registers:** s2_valid, s2_owner, s2_data.
- **Priority register:** last_grant, 1 bit.
- **Stall:** stall = s2_valid & ~resp_ready[s2_owner].
- **Stage-1 enable:** s1_adv = ~s1_valid | ~stall.
- **Arbitration (combinational):**
  - If only one port is valid, it wins.
  - If both are valid, the port ≠ last_grant wins.
  - reqK_ready = s1_adv & win_K.
  - At most one ready is high at any time.
  - A loser's ready is 0; it holds its request stable until accepted.
- **Accept** (valid & ready) at a rising edge:
  - s1 ← {1, K, reqK_in, reqK_cnt}.
  - last_grant ← K.
- **S1 with no accept:** if s1_adv and no port wins, s1_valid ← 0.
- **S1 hold:** when s1_adv = 0, all S1 registers hold.
- **S2 load:** when ~stall, s2 ← {s1_valid, s1_owner, sh_out}.
- **S2 hold:** when stall, all S2 registers hold.
- **Response outputs:**
  - respK_valid = s2_valid & (s2_owner == K).
  - resp_data = s2_data.
- **Shifter drive:** sh_in = s1_in, sh_cnt = s1_cnt, always, even when s1_valid = 0.
- **Reset values:**
  - s1_valid = s2_valid = 0; last_grant = 1, so port 0 wins the first tie.
  - s1_in, s1_cnt, s2_data = 0; owners = 0.
  - Resulting outputs: resp*_valid = 0, busy = 0, sh_in = 0, sh_cnt = 0.
  - reqK_ready = win_K, so ready follows the valids in the first cycle after reset.
- **Reset mid-operation:** in-flight requests are discarded with no response. Requesters must re-issue.
- **Arithmetic:** cnt = 0 passes the operand through unchanged. Bits shifted past bit 15 are lost and zeros fill from the LSB.

## Timing
- **Latency:** accept at edge N → respK_valid high in the cycle after edge N+1, i.e. 2 cycles, provided there is no stall.
- **Throughput:** one accept per cycle while responses are consumed immediately.
- **Stall depth:** two requests can be in flight. With S2 stalled and S1 full, both ready outputs go low in that same cycle (combinational).
- **Release:** the cycle the owner raises respK_ready, S2 loads S1 and a new request can be accepted, with no bubble.
- **Simultaneous events:** consume, advance and accept all happen on the same edge.
- **Non-owner ready:** respJ_ready for the non-owner port J is ignored.
- **Ready ordering:** reqK_ready depends only on registered state, the req valids and resp_ready. It never depends on req_in or req_cnt.

## Test plan
- **Reset, then single request:**
  - Stimulus: rst for 2 cycles; req0 {in=16'h0001, cnt=4}; resp0_ready=1.
  - Response: ready0=1 in cycle 0; resp0_valid and resp_data=16'h0010 two cycles later; resp1_valid stays 0; busy falls afterward.
- **Tie and round-robin:**
  - Stimulus: both ports held valid for 4 cycles after reset; resp ready high.
  - Response: grants go 0,1,0,1; results return in the same order with the correct owner.
  - Values: req1 {16'h8001, cnt=15} returns 16'h8000; req0 {16'hFFFF, cnt=8} returns 16'hFF00.
- **Backpressure:**
  - Stimulus: req0 streams continuously; resp0_ready=0 for 3 cycles.
  - Response: S2 holds its data; after one more accept, ready0 drops; no loss or duplication.
  - Recovery: on the first resp0_ready=1, the stalled result is consumed and a new request is accepted on the same edge.
- **Boundary values:**
  - Stimulus: cnt=0 on 16'hA5A5.
  - Response: 16'hA5A5.
  - Stimulus: cnt=15 on 16'h0003.
  - Response: 16'h8000.
  - Response (both cases): returned data matches the value presented on sh_out.
- **Reset mid-flight:**
  - Stimulus: both stages full with resp ready low; assert rst for 1 cycle.
  - Response: next cycle, busy=0 and resp*_valid=0; none of the discarded results is ever returned; a port-0 tie wins first.
- **Random soak:**
  - Stimulus: 10k cycles of random valids, random resp_ready, random operands.
  - Response: the scoreboard sees every accepted request answered exactly once, in order, and to the correct owner. No port starves for more than 1 cycle while both are valid and the stage-1 enable is high.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and two-stage pipeline controller for a shared 16-bit left shifter.
// Latency: a request accepted at edge N returns its result after edge N+1 (2 cycles), with no stall.
// Backpressure: S2 holds while its owner is not ready; S1 holds when full and S2 stalls; req ready drops combinationally.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqK_valid/in/cnt/ready   request port K (0 = execute, 1 = load/store align)
//   respK_valid/ready         result handshake for port K; resp_data is shared
//   sh_in/sh_cnt/sh_out       drive to and result from the external combinational shifter
//   busy                      any stage holds a valid entry
module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  output logic        req1_ready,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp_data,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_cnt,
  input  logic [15:0] sh_out,
  output logic        busy
);

  logic        r_s1_valid;
  logic        r_s1_owner;
  logic [15:0] r_s1_in;
  logic [3:0]  r_s1_cnt;
  logic        r_s2_valid;
  logic        r_s2_owner;
  logic [15:0] r_s2_data;
  logic        r_last_grant;

  logic        w_owner_rdy;
  logic        w_stall;
  logic        w_s1_adv;
  logic        w_win0;
  logic        w_win1;

  // Only the ready of the port that owns S2 matters; the other one is ignored.
  assign w_owner_rdy = r_s2_owner ? resp1_ready : resp0_ready;
  assign w_stall     = r_s2_valid & ~w_owner_rdy;
  assign w_s1_adv    = ~r_s1_valid | ~w_stall;

  // On a tie the port that did not win last time gets the grant.
  assign w_win0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_win1 = req1_valid & (~req0_valid | ~r_last_grant);

  assign req0_ready = w_s1_adv & w_win0;
  assign req1_ready = w_s1_adv & w_win1;

  assign resp0_valid = r_s2_valid & ~r_s2_owner;
  assign resp1_valid = r_s2_valid &  r_s2_owner;
  assign resp_data   = r_s2_data;

  assign sh_in  = r_s1_in;
  assign sh_cnt = r_s1_cnt;
  assign busy   = r_s1_valid | r_s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_owner   <= 1'b0;
      r_s1_in      <= 16'h0000;
      r_s1_cnt     <= 4'h0;
      r_s2_valid   <= 1'b0;
      r_s2_owner   <= 1'b0;
      r_s2_data    <= 16'h0000;
      r_last_grant <= 1'b1;
    end else begin
      if (w_s1_adv) begin
        if (w_win0) begin
          r_s1_valid   <= 1'b1;
          r_s1_owner   <= 1'b0;
          r_s1_in      <= req0_in;
          r_s1_cnt     <= req0_cnt;
          r_last_grant <= 1'b0;
        end else if (w_win1) begin
          r_s1_valid   <= 1'b1;
          r_s1_owner   <= 1'b1;
          r_s1_in      <= req1_in;
          r_s1_cnt     <= req1_cnt;
          r_last_grant <= 1'b1;
        end else begin
          r_s1_valid <= 1'b0;
        end
      end
      if (!w_stall) begin
        r_s2_valid <= r_s1_valid;
        r_s2_owner <= r_s1_owner;
        r_s2_data  <= sh_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random bench for shift_arbiter with an in-order response scoreboard.
// Latency: checks 2-cycle response timing on directed steps; scoreboard covers ordering elsewhere.
// Backpressure: resp_ready is dropped directly and at random; requesters hold until accepted.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_cnt, req1_cnt;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [15:0] resp_data;
  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [15:0] sh_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Each entry: {owner, expected result}, in acceptance order.
  logic [16:0] sbq[$];

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_in(req0_in), .req0_cnt(req0_cnt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_in(req1_in), .req1_cnt(req1_cnt), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_out(sh_out), .busy(busy)
  );

  // The shared shifter that lives one level up.
  assign sh_out = sh_in << sh_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      sbq.delete();
    end else begin
      chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      chk("one_resp", {31'd0, resp0_valid & resp1_valid}, 32'd0);
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sbq.size() == 0) begin
          chk("spurious_resp", {15'd0, resp1_valid, resp_data}, 32'h1ffff);
        end else begin
          e = sbq.pop_front();
          chk("resp_owner", {31'd0, resp1_valid}, {31'd0, e[16]});
          chk("resp_data", {16'd0, resp_data}, {16'd0, e[15:0]});
        end
      end
      if (req0_valid && req0_ready) sbq.push_back({1'b0, req0_in << req0_cnt});
      if (req1_valid && req1_ready) sbq.push_back({1'b1, req1_in << req1_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_empty", {31'd0, busy}, 32'd0);
    chk("drain_queue", sbq.size(), 32'd0);
  endtask

  initial begin : stim
    int lost0, lost1;
    logic acc0, acc1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_in = 16'h0; req1_in = 16'h0; req0_cnt = 4'h0; req1_cnt = 4'h0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset, then a single request.
    do_reset(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_sh_in", {16'd0, sh_in}, 32'd0);
    chk("rst_sh_cnt", {28'd0, sh_cnt}, 32'd0);
    req0_valid = 1'b1; req0_in = 16'h0001; req0_cnt = 4'd4; resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    chk("single_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_early", {31'd0, resp0_valid}, 32'd0);
    tick();
    chk("single_resp", {14'd0, resp1_valid, resp0_valid, resp_data}, {14'd0, 2'b01, 16'h0010});
    tick();
    chk("single_idle", {30'd0, busy, resp0_valid}, 32'd0);

    // Tie and round-robin from reset.
    do_reset(1);
    req0_valid = 1'b1; req0_in = 16'hFFFF; req0_cnt = 4'd8;
    req1_valid = 1'b1; req1_in = 16'h8001; req1_cnt = 4'd15;
    #1;
    chk("rr_g0", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    chk("rr_g1", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    chk("rr_g2", {30'd0, req1_ready, req0_ready}, 32'd1);
    chk("rr_r0", {14'd0, resp1_valid, resp0_valid, resp_data}, {14'd0, 2'b01, 16'hFF00});
    tick();
    chk("rr_g3", {30'd0, req1_ready, req0_ready}, 32'd2);
    chk("rr_r1", {14'd0, resp1_valid, resp0_valid, resp_data}, {14'd0, 2'b10, 16'h8000});
    tick();
    drain();

    // Backpressure on port 0.
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_in = 16'd1; req0_cnt = 4'd1;
    tick();
    req0_in = 16'd2;
    tick();
    req0_in = 16'd3;
    chk("bp_rdy_low", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("bp_hold0", {15'd0, resp0_valid, resp_data}, {15'd0, 1'b1, 16'd2});
    tick();
    chk("bp_hold1", {15'd0, resp0_valid, resp_data}, {15'd0, 1'b1, 16'd2});
    chk("bp_sh_in", {16'd0, sh_in}, 32'd2);
    resp0_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("bp_next", {15'd0, resp0_valid, resp_data}, {15'd0, 1'b1, 16'd4});
    drain();

    // Boundary counts.
    req0_valid = 1'b1; req0_in = 16'hA5A5; req0_cnt = 4'd0;
    tick();
    req0_valid = 1'b0;
    chk("b0_sh", {12'd0, sh_in, sh_cnt}, {12'd0, 16'hA5A5, 4'd0});
    tick();
    chk("b0_resp", {15'd0, resp0_valid, resp_data}, {15'd0, 1'b1, 16'hA5A5});
    req1_valid = 1'b1; req1_in = 16'h0003; req1_cnt = 4'd15;
    tick();
    req1_valid = 1'b0;
    chk("b15_sh", {12'd0, sh_in, sh_cnt}, {12'd0, 16'h0003, 4'd15});
    tick();
    chk("b15_resp", {15'd0, resp1_valid, resp_data}, {15'd0, 1'b1, 16'h8000});
    drain();

    // Reset with both stages full.
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_in = 16'h1234; req1_cnt = 4'd2;
    tick();
    req1_in = 16'h4321;
    tick();
    req1_valid = 1'b0;
    chk("mf_full", {30'd0, busy, resp1_valid}, 32'd3);
    do_reset(1);
    chk("mf_busy", {31'd0, busy}, 32'd0);
    chk("mf_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    req0_valid = 1'b1; req0_in = 16'h0F0F; req0_cnt = 4'd4;
    req1_valid = 1'b1; req1_in = 16'hF0F0; req1_cnt = 4'd4;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    chk("mf_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    drain();

    // Random soak; each requester holds its request until accepted.
    lost0 = 0; lost1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_in = 16'($urandom); req0_cnt = 4'($urandom);
      end
      if (!req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_in = 16'($urandom); req1_cnt = 4'($urandom);
      end
      resp0_ready = 1'($urandom_range(0, 3) != 0);
      resp1_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      if (req0_valid && req1_valid && (req0_ready || req1_ready)) begin
        if (req0_ready) lost1++; else lost0++;
        chk("starve", lost0 > 1 || lost1 > 1, 32'd0);
      end
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (acc0) lost0 = 0;
      if (acc1) lost1 = 0;
      @(posedge clk);
      #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
